// File: rtl/fc_link_bringup.sv
// Transceiver link bring-up sequencer: PLL reset/lock, TX reset release, RX CDR
// lock-to-data qualification, word sync acquisition and link supervision.
module fc_link_bringup #(
  parameter int unsigned PLL_RST_CYC  = 1000,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned TX_DIG_DLY   = 100,
  parameter int unsigned LTD_CYC      = 1000,
  parameter int unsigned SYNC_TIMEOUT = 100000,
  parameter int unsigned LOSS_CYC     = 16,
  parameter int unsigned SYNC_W       = 4
) (
  input  logic              mgmt_clk,
  input  logic              mgmt_reset_n,
  input  logic              restart,
  input  logic              pll_locked,
  input  logic              rx_is_lockedtodata,
  input  logic [SYNC_W-1:0] rx_syncstatus,
  output logic              pll_powerdown,
  output logic              tx_analogreset,
  output logic              tx_digitalreset,
  output logic              rx_analogreset,
  output logic              rx_digitalreset,
  output logic              link_up,
  output logic [2:0]        state,
  output logic [7:0]        retry_count
);

  localparam logic [2:0] PLL_RST   = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] TX_RST    = 3'd2;
  localparam logic [2:0] RX_CDR    = 3'd3;
  localparam logic [2:0] WAIT_SYNC = 3'd4;
  localparam logic [2:0] LINK_UP   = 3'd5;

  localparam logic [23:0] PLL_LAST  = 24'(PLL_RST_CYC - 1);
  localparam logic [23:0] LOCK_LAST = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] TX_DLY    = 24'(TX_DIG_DLY);
  localparam logic [23:0] LTD_LAST  = 24'(LTD_CYC - 1);
  localparam logic [23:0] SYNC_LAST = 24'(SYNC_TIMEOUT - 1);
  localparam logic [23:0] LOSS_LAST = 24'(LOSS_CYC - 1);

  logic [1:0]        pll_sync, ltd_sync;
  logic [SYNC_W-1:0] ss_meta, ss_sync;
  logic              pll_ok, ltd_ok, sync_ok;

  logic [2:0]  st, st_nx;
  logic [23:0] cnt, cnt_nx;
  logic        retry_inc;
  logic [4:0]  rst_q, rst_nx;
  logic        link_q, link_nx;
  logic [7:0]  retry_q;

  always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
    if (!mgmt_reset_n) begin
      pll_sync <= '0;
      ltd_sync <= '0;
      ss_meta  <= '0;
      ss_sync  <= '0;
    end else begin
      pll_sync <= {pll_sync[0], pll_locked};
      ltd_sync <= {ltd_sync[0], rx_is_lockedtodata};
      ss_meta  <= rx_syncstatus;
      ss_sync  <= ss_meta;
    end
  end

  assign pll_ok  = pll_sync[1];
  assign ltd_ok  = ltd_sync[1];
  assign sync_ok = &ss_sync;

  always_comb begin
    st_nx     = st;
    cnt_nx    = cnt + 24'd1;
    retry_inc = 1'b0;
    case (st)
      PLL_RST: if (cnt == PLL_LAST) st_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        if (pll_ok) st_nx = TX_RST;
        else if (cnt == LOCK_LAST) begin st_nx = PLL_RST; retry_inc = 1'b1; end
      end
      TX_RST: if (cnt >= TX_DLY) st_nx = RX_CDR;
      // counter doubles as the consecutive lock-to-data run length
      RX_CDR: begin
        if (!ltd_ok) cnt_nx = '0;
        else if (cnt == LTD_LAST) st_nx = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (!ltd_ok) begin st_nx = RX_CDR; retry_inc = 1'b1; end
        else if (sync_ok) st_nx = LINK_UP;
        else if (cnt == SYNC_LAST) begin st_nx = RX_CDR; retry_inc = 1'b1; end
      end
      // counter doubles as the consecutive sync-loss run length
      LINK_UP: begin
        if (!ltd_ok) begin st_nx = RX_CDR; retry_inc = 1'b1; end
        else if (sync_ok) cnt_nx = '0;
        else if (cnt == LOSS_LAST) begin st_nx = RX_CDR; retry_inc = 1'b1; end
      end
      default: st_nx = PLL_RST;
    endcase
    if (!pll_ok && (st inside {TX_RST, RX_CDR, WAIT_SYNC, LINK_UP})) begin
      st_nx     = PLL_RST;
      retry_inc = 1'b1;
    end
    if (restart) begin
      st_nx     = PLL_RST;
      retry_inc = 1'b0;
    end
    if (st_nx != st || restart) cnt_nx = '0;
  end

  // Outputs are decoded from next state/count so they move with the state register.
  always_comb begin
    rst_nx  = 5'b11111;
    link_nx = 1'b0;
    case (st_nx)
      WAIT_LOCK: rst_nx = 5'b01111;
      TX_RST:    rst_nx = {2'b00, (cnt_nx < TX_DLY), 2'b11};
      RX_CDR:    rst_nx = 5'b00001;
      WAIT_SYNC: rst_nx = 5'b00000;
      LINK_UP: begin
        rst_nx  = 5'b00000;
        link_nx = 1'b1;
      end
      default:   rst_nx = 5'b11111;
    endcase
  end

  always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
    if (!mgmt_reset_n) begin
      st      <= PLL_RST;
      cnt     <= '0;
      rst_q   <= '1;
      link_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      st     <= st_nx;
      cnt    <= cnt_nx;
      rst_q  <= rst_nx;
      link_q <= link_nx;
      if (retry_inc && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
    end
  end

  assign {pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset} = rst_q;
  assign link_up     = link_q;
  assign state       = st;
  assign retry_count = retry_q;

endmodule
